// File: rtl/dh_pkg.sv
// Shared constants and state type for the Diffie-Hellman datapath
// (exponentiation unit and the modular reduction stage).
package dh_pkg;
  localparam int VALUE_W = 64;
  localparam int MOD_W   = 32;
  localparam int CNT_W   = $clog2(VALUE_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/dh_mod_step.sv
// One restoring compare-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the modulus when it fits.
module dh_mod_step #(
  parameter int MOD_W = 32
) (
  input  logic [MOD_W-1:0] r,
  input  logic             din,
  input  logic [MOD_W-1:0] m,
  output logic [MOD_W-1:0] r_nxt
);
  logic [MOD_W:0] t;
  logic [MOD_W:0] diff;

  // t is one bit wider than the modulus, so a full-width m never overflows
  always_comb begin
    t    = {r, din};
    diff = t - {1'b0, m};
    if (t >= {1'b0, m}) r_nxt = diff[MOD_W-1:0];
    else                r_nxt = t[MOD_W-1:0];
  end
endmodule

// File: rtl/dh_mod_reduce.sv
// Sequential value mod modulus, one dividend bit per clock with a fixed
// VALUE_W-cycle run, using a start/done level handshake.
module dh_mod_reduce #(
  parameter int VALUE_W = dh_pkg::VALUE_W,
  parameter int MOD_W   = dh_pkg::MOD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  input  logic [MOD_W-1:0]   modulus,
  output logic [MOD_W-1:0]   result,
  output logic               done,
  output logic               busy,
  output logic               err
);
  import dh_pkg::*;

  localparam int CW = $clog2(VALUE_W + 1);

  state_t             state;
  logic [VALUE_W-1:0] d;
  logic [MOD_W-1:0]   m;
  logic [MOD_W-1:0]   r;
  logic [MOD_W-1:0]   r_nxt;
  logic [CW-1:0]      cnt;

  dh_mod_step #(.MOD_W(MOD_W)) u_step (
    .r     (r),
    .din   (d[VALUE_W-1]),
    .m     (m),
    .r_nxt (r_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      d      <= '0;
      m      <= '0;
      r      <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (modulus != '0) begin
              d     <= value;
              m     <= modulus;
              r     <= '0;
              cnt   <= CW'(VALUE_W);
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              // division by zero: report immediately instead of running
              result <= '0;
              err    <= 1'b1;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        RUN: begin
          r   <= r_nxt;
          d   <= d << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= r_nxt;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // a new request needs start to fall first
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dh_mod_reduce.sv
// Scoreboard bench for dh_mod_reduce: directed vectors push expected
// {err, result}; a monitor pops on each rising done.
module tb_dh_mod_reduce;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] value;
  logic [31:0] modulus;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        err;

  int          nvec = 0;
  int          nbad = 0;
  logic [32:0] sb_q[$];
  logic        done_prev = 1'b0;

  dh_mod_reduce dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .value   (value),
    .modulus (modulus),
    .result  (result),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: compare result/err on every rising edge of done
  always @(negedge clk) begin
    if (!rst && done && !done_prev) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 1, 0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("sb_result", result, e[31:0]);
        chk("sb_err", err, e[32]);
      end
    end
    done_prev <= done;
  end

  // mode 0: start pulse; 1: start held through done; 2: disturb inputs mid-run
  task automatic run_vec(input logic [63:0] v, input logic [31:0] mo, input logic [31:0] er,
                         input logic ee, input int lat, input int mode);
    int n;
    @(negedge clk);
    value = v; modulus = mo; start = 1'b1;
    sb_q.push_back({ee, er});
    @(posedge clk); #1;
    n = 1;
    if (mode != 1) start = 1'b0;
    if (lat > 1) chk("busy_run", busy, 1);
    while (!done && n < 200) begin
      if (mode == 2 && n == 10) begin value = 64'd5; modulus = 32'd3; start = 1'b1; end
      if (mode == 2 && n == 12) start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    chk("busy_done", busy, 0);
    if (mode == 1) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("hold_done", done, 1);
        chk("hold_result", result, er);
      end
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      chk("drop_done", done, 0);
    end else begin
      @(posedge clk); #1;
      chk("pulse_done", done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; value = '0; modulus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst = 1'b0;

    run_vec(64'h0000_0001_0000_0000, 32'd7, 32'd4, 1'b0, 65, 0);
    run_vec(64'd15625, 32'd23, 32'd8, 1'b0, 65, 1);
    run_vec(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 65, 0);
    run_vec(64'd100, 32'hFFFF_FFFB, 32'd100, 1'b0, 65, 0);
    run_vec(64'd123, 32'd0, 32'd0, 1'b1, 1, 0);
    run_vec(64'd9, 32'd7, 32'd2, 1'b0, 65, 0);

    // abort a run with reset at RUN cycle 30
    @(negedge clk);
    value = 64'd1000; modulus = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    @(negedge clk); rst = 1'b0;

    run_vec(64'd1000, 32'd13, 32'd12, 1'b0, 65, 0);
    run_vec(64'd1000, 32'd7, 32'd6, 1'b0, 65, 2);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
